// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to the idle-high level.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable framing and a valid/ready output slot.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    logic                 rx_s;
    state_t               state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [3:0]           bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 stop_bad, stop_bad_n;
    logic                 par_bad, par_bad_n;
    logic                 complete;
    logic                 slot_free;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            stop_bad <= 1'b0;
            par_bad  <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            stop_bad <= stop_bad_n;
            par_bad  <= par_bad_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_n     = tick_cnt;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        stop_bad_n = stop_bad;
        par_bad_n  = par_bad;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt == HALF) begin
                        // Still low at half a bit: a real start bit
                        if (!rx_s) begin
                            state_n    = DATA;
                            tick_n     = '0;
                            bit_n      = '0;
                            shreg_n    = '0;
                            stop_bad_n = 1'b0;
                            par_bad_n  = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt == LAST) begin
                        tick_n = '0;
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_cnt == 4'(i)) shreg_n[i] = rx_s;
                        end
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_n   = '0;
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (tick_cnt == LAST) begin
                        tick_n    = '0;
                        par_bad_n = ((^shreg) ^ rx_s) != (PARITY_ODD != 0);
                        state_n   = STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt == LAST) begin
                        tick_n     = '0;
                        stop_bad_n = stop_bad | ~rx_s;
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            complete = 1'b1;
                            bit_n    = '0;
                            state_n  = stop_bad_n ? BREAK_WAIT : IDLE;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            BREAK_WAIT: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= complete && !slot_free;
            if (complete && slot_free) begin
                out_data   <= shreg;
                frame_err  <= stop_bad_n;
                parity_err <= par_bad;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 and 8E1 instances on a shared clock.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [1:0] div = 2'd0;

    logic       rx_a, rdy_a;
    logic [7:0] a_data;
    logic       a_valid, a_fe, a_pe, a_ovr;

    logic       rx_b, rdy_b;
    logic [7:0] b_data;
    logic       b_valid, b_fe, b_pe, b_ovr;

    int n_assert = 0;
    int n_fail   = 0;

    int         na = 0, nb = 0, ovr_cycles = 0;
    logic [7:0] la_data, lb_data;
    logic       la_fe, la_pe, lb_pe;

    always #5 clk = ~clk;

    always @(posedge clk) div <= div + 2'd1;
    assign baud_tick = (div == 2'd3);

    uart_rx_param u_a (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .uart_rx     (rx_a),
        .out_data    (a_data),
        .out_valid   (a_valid),
        .out_ready   (rdy_a),
        .frame_err   (a_fe),
        .parity_err  (a_pe),
        .overrun_err (a_ovr)
    );

    uart_rx_param #(
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) u_b (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .uart_rx     (rx_b),
        .out_data    (b_data),
        .out_valid   (b_valid),
        .out_ready   (rdy_b),
        .frame_err   (b_fe),
        .parity_err  (b_pe),
        .overrun_err (b_ovr)
    );

    // Record accepted frames and overrun pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (a_valid && rdy_a) begin
            na = na + 1;
            la_data = a_data;
            la_fe = a_fe;
            la_pe = a_pe;
        end
        if (b_valid && rdy_b) begin
            nb = nb + 1;
            lb_data = b_data;
            lb_pe = b_pe;
        end
        if (a_ovr) ovr_cycles = ovr_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else rx_a = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] d,
                        input bit use_par, input bit p, input bit stop);
        drive(sel, 1'b0);
        tick(64);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            tick(64);
        end
        if (use_par) begin
            drive(sel, p);
            tick(64);
        end
        drive(sel, stop);
        tick(64);
        if (stop) tick(64);
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_data", 32'(a_data), 32'h0);
        chk("rst_fe", 32'(a_fe), 32'h0);
        chk("rst_pe", 32'(a_pe), 32'h0);
        chk("rst_ovr", 32'(a_ovr), 32'h0);

        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("a5_count", 32'(na), 32'd1);
        chk("a5_data", 32'(la_data), 32'hA5);
        chk("a5_fe", 32'(la_fe), 32'h0);
        chk("a5_pe", 32'(la_pe), 32'h0);

        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        chk("par_ok_count", 32'(nb), 32'd1);
        chk("par_ok_pe", 32'(lb_pe), 32'h0);
        send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        chk("par_bad_count", 32'(nb), 32'd2);
        chk("par_bad_data", 32'(lb_data), 32'h07);
        chk("par_bad_pe", 32'(lb_pe), 32'h1);

        drive(1'b0, 1'b0);
        tick(16);
        drive(1'b0, 1'b1);
        tick(128);
        chk("glitch_none", 32'(na), 32'd1);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        chk("3c_count", 32'(na), 32'd2);
        chk("3c_data", 32'(la_data), 32'h3C);

        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("55_data", 32'(la_data), 32'h55);
        chk("55_fe", 32'(la_fe), 32'h1);
        tick(40 * 64);
        chk("break_none", 32'(na), 32'd3);
        drive(1'b0, 1'b1);
        tick(128);
        send(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        chk("12_count", 32'(na), 32'd4);
        chk("12_data", 32'(la_data), 32'h12);
        chk("12_fe", 32'(la_fe), 32'h0);

        rdy_a = 1'b0;
        send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        chk("ovr_hold_valid", 32'(a_valid), 32'h1);
        chk("ovr_hold_data", 32'(a_data), 32'h11);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        chk("ovr_pulse", 32'(ovr_cycles), 32'd1);
        chk("ovr_keep_data", 32'(a_data), 32'h11);
        chk("ovr_keep_valid", 32'(a_valid), 32'h1);
        rdy_a = 1'b1;
        tick(3);
        chk("ovr_acc_count", 32'(na), 32'd5);
        chk("ovr_acc_data", 32'(la_data), 32'h11);
        chk("ovr_acc_valid", 32'(a_valid), 32'h0);

        drive(1'b0, 1'b0);
        tick(64 * 4 + 16);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", 32'(a_data), 32'h0);
        chk("mid_rst_valid", 32'(a_valid), 32'h0);
        chk("mid_rst_fe", 32'(a_fe), 32'h0);
        chk("mid_rst_pe", 32'(a_pe), 32'h0);
        chk("mid_rst_ovr", 32'(a_ovr), 32'h0);
        drive(1'b0, 1'b1);
        tick(3);
        rst = 1'b0;
        tick(128);
        chk("post_rst_none", 32'(na), 32'd5);
        send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        chk("81_count", 32'(na), 32'd6);
        chk("81_data", 32'(la_data), 32'h81);
        chk("81_fe", 32'(la_fe), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
